// File: rtl/random_word_collector.sv
// Packs strobed random bits MSB-first into WIDTH-bit words behind a 2-entry
// output buffer, with a sticky repetition-count health test.
module random_word_collector #(
  parameter int WIDTH     = 8,
  parameter int REP_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_strobe,
  input  logic             bit_in,
  input  logic             clear_fail,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             health_fail,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic {COLLECT, FAILED} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-2:0] partial;
  logic [RW-1:0]    run, run_next;
  logic             last_bit;
  logic [WIDTH-1:0] head, tail, shifted;
  logic             head_v, tail_v;
  logic             accept, trip, complete, push, drop, pop;

  assign shifted    = {partial, bit_in};
  assign pop        = head_v && word_ready;
  assign word_out   = head;
  assign word_valid = head_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_fail)  state_next = COLLECT;
    else if (trip)   state_next = FAILED;
  end

  // run == 0 marks "no previous bit" after reset or clear_fail
  always_comb begin
    accept   = (state == COLLECT) && bit_strobe && !clear_fail;
    run_next = RW'(1);
    if (run != '0 && bit_in == last_bit)
      run_next = (run == RW'(REP_LIMIT)) ? run : run + RW'(1);
    trip     = accept && (run_next == RW'(REP_LIMIT));
    complete = accept && !trip && (count == CW'(WIDTH - 1));
    push     = complete && (!tail_v || pop);
    drop     = complete && !push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      partial     <= '0;
      run         <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear_fail) begin
      count       <= '0;
      partial     <= '0;
      run         <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      run      <= run_next;
      last_bit <= bit_in;
      if (trip) begin
        count       <= '0;
        partial     <= '0;
        health_fail <= 1'b1;
      end else if (complete) begin
        count <= '0;
        if (drop) overflow <= 1'b1;
      end else begin
        count   <= count + CW'(1);
        partial <= shifted[WIDTH-2:0];
      end
    end
  end

  // Head register drives word_out directly; tail shifts forward on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      head_v <= 1'b0;
      tail_v <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!head_v) begin
            head   <= shifted;
            head_v <= 1'b1;
          end else begin
            tail   <= shifted;
            tail_v <= 1'b1;
          end
        end
        2'b01: begin
          if (tail_v) begin
            head   <= tail;
            tail_v <= 1'b0;
          end else begin
            head_v <= 1'b0;
          end
        end
        2'b11: begin
          if (tail_v) begin
            head <= tail;
            tail <= shifted;
          end else begin
            head <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_random_word_collector.sv
// Scoreboard bench: a bit-queue reference model predicts accepted words and
// sticky flags; a negedge monitor checks every pop and the flag outputs.
module tb_random_word_collector;

  localparam int W = 8;
  localparam int L = 16;

  logic         clk, rst_n, bit_strobe, bit_in, clear_fail, word_ready;
  logic [W-1:0] word_out;
  logic         word_valid, health_fail, overflow;

  random_word_collector #(.WIDTH(W), .REP_LIMIT(L)) dut (
    .clk(clk), .rst_n(rst_n), .bit_strobe(bit_strobe), .bit_in(bit_in),
    .clear_fail(clear_fail), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .health_fail(health_fail), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 0;

  int           m_occ;
  bit           m_failed, m_hf, m_ov, m_last;
  int           m_run;
  bit           m_bits[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_failed = 0; m_hf = 0; m_ov = 0; m_last = 0; m_run = 0;
    m_bits.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input bit s, input bit b, input bit r, input bit c);
    bit pop, push;
    logic [W-1:0] w;
    pop  = r && (m_occ > 0);
    push = 0;
    if (c) begin
      m_hf = 0; m_ov = 0; m_failed = 0; m_run = 0;
      m_bits.delete();
    end else if (s && !m_failed) begin
      if (m_run == 0 || b != m_last) m_run = 1;
      else if (m_run < L) m_run++;
      m_last = b;
      if (m_run == L) begin
        m_failed = 1; m_hf = 1;
        m_bits.delete();
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == W) begin
          w = '0;
          foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
          if (m_occ < 2 || pop) begin
            exp_q.push_back(w);
            push = 1;
          end else m_ov = 1;
          m_bits.delete();
        end
      end
    end
    m_occ = m_occ - int'(pop) + int'(push);
  endtask

  task automatic cycle(input bit s, input bit b, input bit r, input bit c);
    bit_strobe = s; bit_in = b; word_ready = r; clear_fail = c;
    @(posedge clk);
    #1;
    model_step(s, b, r, c);
  endtask

  task automatic feed_word(input logic [W-1:0] w, input bit r);
    for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bit_strobe = 0; bit_in = 0; word_ready = 0; clear_fail = 0;
    #2;
    check("rst_valid", {31'd0, word_valid}, 0);
    check("rst_word", {24'd0, word_out}, 0);
    check("rst_health", {31'd0, health_fail}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_valid", {31'd0, word_valid}, {31'd0, m_occ > 0});
      check("mon_health", {31'd0, health_fail}, {31'd0, m_hf});
      check("mon_overflow", {31'd0, overflow}, {31'd0, m_ov});
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL pop_unexpected: got %0h expected none", word_out);
        end else begin
          check("pop_word", {24'd0, word_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bit_strobe = 0; bit_in = 0; word_ready = 0; clear_fail = 0;
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1;

    // B2 with consumer ready
    feed_word(8'hB2, 1'b1);
    check("b2_valid", {31'd0, word_valid}, 1);
    check("b2_word", {24'd0, word_out}, 32'hB2);
    idle(2, 1'b1);
    check("b2_popped", {31'd0, word_valid}, 0);

    // three words into a stalled buffer
    feed_word(8'hA5, 1'b0);
    feed_word(8'h3C, 1'b0);
    feed_word(8'h5A, 1'b0);
    check("ovf_set", {31'd0, overflow}, 1);
    check("ovf_head", {24'd0, word_out}, 32'hA5);
    idle(3, 1'b1);
    check("ovf_drained", {31'd0, word_valid}, 0);

    // 16 ones trip the health test
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("ff_head", {24'd0, word_out}, 32'hFF);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("trip_health", {31'd0, health_fail}, 1);
    for (int i = 0; i < 6; i++) cycle(1'b1, i[0], 1'b0, 1'b0);
    check("trip_ignored_valid", {31'd0, word_valid}, 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("clear_health", {31'd0, health_fail}, 0);
    check("clear_overflow", {31'd0, overflow}, 0);
    feed_word(8'h97, 1'b0);
    idle(3, 1'b1);

    // 15 zeros then a 1: no trip
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("run15_health", {31'd0, health_fail}, 0);
    idle(2, 1'b1);

    // completion coinciding with a pop at full
    feed_word(8'h12, 1'b0);
    feed_word(8'h34, 1'b0);
    for (int i = W - 1; i >= 1; i--) cycle(1'b1, i[0] ^ i[1] ^ 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("full_pop_ovf", {31'd0, overflow}, 0);
    check("full_pop_valid", {31'd0, word_valid}, 1);
    idle(3, 1'b1);

    // reset mid-word
    for (int i = 0; i < 5; i++) cycle(1'b1, i[0], 1'b1, 1'b0);
    do_reset();
    feed_word(8'h69, 1'b1);
    check("post_rst_word", {24'd0, word_out}, 32'h69);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit s, b, r, c, bias;
      bias = ((i / 200) % 2) == 1;
      s = $urandom_range(0, 3) != 0;
      b = bias ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
      r = $urandom_range(0, 2) != 0;
      c = ($urandom_range(0, 99) == 0) || (m_hf && $urandom_range(0, 19) == 0);
      cycle(s, b, r, c);
    end
    idle(4, 1'b1);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid", {31'd0, word_valid}, 0);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
